// File: rtl/cix_offload_controller_pkg.sv
// Shared widths, instruction field positions and slot-entry type for the
// custom-instruction offload controller.
package cix_pkg;

    localparam int CIX_ID_W = 4;
    localparam int CIX_RD_W = 5;
    localparam int CIX_XLEN = 32;
    localparam int CIX_FUNCT_W = 10;

    localparam int CIX_OPCODE_LSB = 0;
    localparam int CIX_OPCODE_MSB = 6;
    localparam int CIX_RD_LSB     = 7;
    localparam int CIX_RD_MSB     = 11;
    localparam int CIX_FUNCT3_LSB = 12;
    localparam int CIX_FUNCT3_MSB = 14;
    localparam int CIX_FUNCT7_LSB = 25;
    localparam int CIX_FUNCT7_MSB = 31;

    typedef struct packed {
        logic                valid;
        logic [CIX_ID_W-1:0] id;
        logic [CIX_RD_W-1:0] rd;
    } cix_slot_t;

    // Accelerator sees {funct7, funct3} as one operation selector.
    function automatic logic [CIX_FUNCT_W-1:0] cix_funct(input logic [CIX_XLEN-1:0] instr);
        return {instr[CIX_FUNCT7_MSB:CIX_FUNCT7_LSB], instr[CIX_FUNCT3_MSB:CIX_FUNCT3_LSB]};
    endfunction

endpackage

// File: rtl/cix_offload_controller_if.sv
// Issue/result channel between CPU, offload controller and one fabric accelerator.
// The controller uses the slave view; the CPU/accelerator side uses the master view.
interface cix_offload_controller_if #(
    parameter int NUM_SLOTS = 4,
    parameter int TAG_W     = $clog2(NUM_SLOTS)
);
    logic        issue_valid_i;
    logic [31:0] issue_instr_i;
    logic [31:0] issue_opa_i;
    logic [31:0] issue_opb_i;
    logic [3:0]  issue_id_i;
    logic        issue_ready_o;
    logic        issue_accept_o;

    logic             acc_req_valid_o;
    logic             acc_req_ready_i;
    logic [9:0]       acc_req_funct_o;
    logic [31:0]      acc_req_opa_o;
    logic [31:0]      acc_req_opb_o;
    logic [TAG_W-1:0] acc_req_tag_o;

    logic             acc_rsp_valid_i;
    logic [TAG_W-1:0] acc_rsp_tag_i;
    logic [31:0]      acc_rsp_data_i;

    logic        result_valid_o;
    logic [3:0]  result_id_o;
    logic [4:0]  result_rd_o;
    logic [31:0] result_data_o;
    logic        busy_o;
    logic        err_o;

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_opa_i, issue_opb_i, issue_id_i,
        output issue_ready_o, issue_accept_o,
        output acc_req_valid_o, acc_req_funct_o, acc_req_opa_o, acc_req_opb_o, acc_req_tag_o,
        input  acc_req_ready_i,
        input  acc_rsp_valid_i, acc_rsp_tag_i, acc_rsp_data_i,
        output result_valid_o, result_id_o, result_rd_o, result_data_o, busy_o, err_o
    );

    modport master (
        output issue_valid_i, issue_instr_i, issue_opa_i, issue_opb_i, issue_id_i,
        input  issue_ready_o, issue_accept_o,
        input  acc_req_valid_o, acc_req_funct_o, acc_req_opa_o, acc_req_opb_o, acc_req_tag_o,
        output acc_req_ready_i,
        output acc_rsp_valid_i, acc_rsp_tag_i, acc_rsp_data_i,
        input  result_valid_o, result_id_o, result_rd_o, result_data_o, busy_o, err_o
    );

endinterface

// File: rtl/cix_offload_controller_slot_table.sv
// Outstanding-instruction scoreboard: lowest-free allocator, free and lookup by tag.
// A slot freed this cycle only becomes allocatable from the next cycle on.
module cix_slot_table
    import cix_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int TAG_W     = $clog2(NUM_SLOTS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_alloc_en,
    input  logic [CIX_ID_W-1:0] i_alloc_id,
    input  logic [CIX_RD_W-1:0] i_alloc_rd,
    output logic [TAG_W-1:0]    o_alloc_tag,
    output logic                o_full,
    input  logic                i_free_en,
    input  logic [TAG_W-1:0]    i_free_tag,
    input  logic [TAG_W-1:0]    i_lookup_tag,
    output cix_slot_t           o_lookup,
    output logic                o_any_valid_next
);

    cix_slot_t              r_slots [NUM_SLOTS];
    logic [TAG_W-1:0]       w_alloc_tag;
    logic                   w_found;
    logic [NUM_SLOTS-1:0]   w_valid_next;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_alloc_tag = '0;
        w_found     = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_slots[i].valid) begin
                w_alloc_tag = TAG_W'(i);
                w_found     = 1'b1;
            end
        end
    end

    always_comb begin
        w_valid_next = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_valid_next[i] = r_slots[i].valid;
            if (i_free_en && (i_free_tag == TAG_W'(i)))
                w_valid_next[i] = 1'b0;
            if (i_alloc_en && (w_alloc_tag == TAG_W'(i)))
                w_valid_next[i] = 1'b1;
        end
    end

    // NOTE: the table is a handful of flops, so it is fully reset; large RAM-style arrays would not be.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++)
                r_slots[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (i_free_en && (i_free_tag == TAG_W'(i)))
                    r_slots[i].valid <= 1'b0;
                if (i_alloc_en && (w_alloc_tag == TAG_W'(i)))
                    r_slots[i] <= '{valid: 1'b1, id: i_alloc_id, rd: i_alloc_rd};
            end
        end
    end

    assign o_alloc_tag      = w_alloc_tag;
    assign o_full           = !w_found;
    assign o_lookup         = r_slots[i_lookup_tag];
    assign o_any_valid_next = |w_valid_next;

endmodule

// File: rtl/cix_offload_controller.sv
// Fabric-side sequencer for the custom-instruction channel: decodes issues, forwards
// accepted ones to the accelerator and maps out-of-order completions back to the CPU.
module cix_offload_controller
    import cix_pkg::*;
#(
    parameter int         NUM_SLOTS = 4,
    parameter logic [6:0] OPCODE    = 7'b0001011,
    parameter int         TAG_W     = $clog2(NUM_SLOTS)
) (
    input  logic                    UserCLK,
    input  logic                    resetn,
    cix_offload_controller_if.slave bus
);

    logic             w_match;
    logic             w_full;
    logic             w_can_take;
    logic             w_issue_ready;
    logic             w_issue_accept;
    logic             w_req_fire;
    logic             w_req_valid_next;
    logic             w_any_valid_next;
    logic             w_rsp_hit;
    logic             w_rsp_stale;
    logic [TAG_W-1:0] w_alloc_tag;
    cix_slot_t        w_lookup;

    logic                   r_req_valid;
    logic [CIX_FUNCT_W-1:0] r_req_funct;
    logic [CIX_XLEN-1:0]    r_req_opa;
    logic [CIX_XLEN-1:0]    r_req_opb;
    logic [TAG_W-1:0]       r_req_tag;
    logic                   r_result_valid;
    logic [CIX_ID_W-1:0]    r_result_id;
    logic [CIX_RD_W-1:0]    r_result_rd;
    logic [CIX_XLEN-1:0]    r_result_data;
    logic                   r_busy;
    logic                   r_err;

    assign w_match    = (bus.issue_instr_i[CIX_OPCODE_MSB:CIX_OPCODE_LSB] == OPCODE);
    assign w_req_fire = r_req_valid && bus.acc_req_ready_i;
    assign w_can_take = !w_full && (!r_req_valid || w_req_fire);

    // Issue valid is masked while in reset so the handshake outputs read 0 there.
    assign w_issue_ready    = resetn && bus.issue_valid_i && (!w_match || w_can_take);
    assign w_issue_accept   = w_issue_ready && w_match;
    assign w_req_valid_next = w_issue_accept || (r_req_valid && !w_req_fire);

    assign w_rsp_hit   = bus.acc_rsp_valid_i && w_lookup.valid;
    assign w_rsp_stale = bus.acc_rsp_valid_i && !w_lookup.valid;

    cix_slot_table #(
        .NUM_SLOTS (NUM_SLOTS),
        .TAG_W     (TAG_W)
    ) u_slot_table (
        .clk              (UserCLK),
        .rst_n            (resetn),
        .i_alloc_en       (w_issue_accept),
        .i_alloc_id       (bus.issue_id_i),
        .i_alloc_rd       (bus.issue_instr_i[CIX_RD_MSB:CIX_RD_LSB]),
        .o_alloc_tag      (w_alloc_tag),
        .o_full           (w_full),
        .i_free_en        (w_rsp_hit),
        .i_free_tag       (bus.acc_rsp_tag_i),
        .i_lookup_tag     (bus.acc_rsp_tag_i),
        .o_lookup         (w_lookup),
        .o_any_valid_next (w_any_valid_next)
    );

    // One-entry request register; a new accept may reload it in the cycle it drains.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            r_req_valid <= 1'b0;
            r_req_funct <= '0;
            r_req_opa   <= '0;
            r_req_opb   <= '0;
            r_req_tag   <= '0;
        end else begin
            r_req_valid <= w_req_valid_next;
            if (w_issue_accept) begin
                r_req_funct <= cix_funct(bus.issue_instr_i);
                r_req_opa   <= bus.issue_opa_i;
                r_req_opb   <= bus.issue_opb_i;
                r_req_tag   <= w_alloc_tag;
            end
        end
    end

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            r_result_valid <= 1'b0;
            r_result_id    <= '0;
            r_result_rd    <= '0;
            r_result_data  <= '0;
        end else begin
            r_result_valid <= w_rsp_hit;
            if (w_rsp_hit) begin
                r_result_id   <= w_lookup.id;
                r_result_rd   <= w_lookup.rd;
                r_result_data <= bus.acc_rsp_data_i;
            end
        end
    end

    // Busy is built from next-state values so it lines up with the state it summarises.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            r_busy <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_any_valid_next || w_req_valid_next;
            if (w_rsp_stale)
                r_err <= 1'b1;
        end
    end

    assign bus.issue_ready_o   = w_issue_ready;
    assign bus.issue_accept_o  = w_issue_accept;
    assign bus.acc_req_valid_o = r_req_valid;
    assign bus.acc_req_funct_o = r_req_funct;
    assign bus.acc_req_opa_o   = r_req_opa;
    assign bus.acc_req_opb_o   = r_req_opb;
    assign bus.acc_req_tag_o   = r_req_tag;
    assign bus.result_valid_o  = r_result_valid;
    assign bus.result_id_o     = r_result_id;
    assign bus.result_rd_o     = r_result_rd;
    assign bus.result_data_o   = r_result_data;
    assign bus.busy_o          = r_busy;
    assign bus.err_o           = r_err;

endmodule

// File: doc/cix_offload_controller.md
Name: cix_offload_controller

Overview:
- Fabric-side sequencer for the custom-instruction (CV-X-IF style) issue/result channel between the CPU and one user accelerator in the FPGA fabric.
- Decodes and accepts or rejects issued instructions, and forwards accepted ones to the accelerator through a one-entry request register.
- Tracks outstanding instructions in a slot scoreboard, so the accelerator may complete out of order.
- Maps each accelerator completion back to the CPU's instruction ID and destination register and emits a registered result.

Parameters:
- NUM_SLOTS, 4, outstanding-instruction slots; power of two, 2..16.
- OPCODE, 7'b0001011, instr[6:0] value claimed by this block (custom-0).
- TAG_W, $clog2(NUM_SLOTS), slot tag width.

Ports:
- UserCLK  in  1  clock; all state is on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- issue_valid_i  in  1  CPU issue request.
- issue_instr_i  in  32  instruction word.
- issue_opa_i  in  32  rs1 value.
- issue_opb_i  in  32  rs2 value.
- issue_id_i  in  4  CPU instruction ID.
- issue_ready_o  out  1  issue handshake completes this cycle.
- issue_accept_o  out  1  instruction claimed; valid only while issue_ready_o=1.
- acc_req_valid_o  out  1  request to accelerator.
- acc_req_ready_i  in  1  accelerator takes request.
- acc_req_funct_o  out  10  {funct7, funct3}.
- acc_req_opa_o  out  32  rs1 value to accelerator.
- acc_req_opb_o  out  32  rs2 value to accelerator.
- acc_req_tag_o  out  TAG_W  slot index.
- acc_rsp_valid_i  in  1  accelerator completion.
- acc_rsp_tag_i  in  TAG_W  completing slot.
- acc_rsp_data_i  in  32  result data.
- result_valid_o  out  1  one-cycle result pulse to CPU.
- result_id_o  out  4  ID of the completed instruction.
- result_rd_o  out  5  destination register.
- result_data_o  out  32  result value.
- busy_o  out  1  any slot valid or request pending.
- err_o  out  1  sticky: response to a non-valid slot.

Behaviour:
- Reset (asynchronous, resetn=0): all slot valid bits 0, request register empty, err_o=0. Every output is 0 except the combinational issue_ready_o/issue_accept_o, which evaluate to 0 because issue_valid_i is ignored during reset.
- match = (issue_instr_i[6:0]==OPCODE).
- can_take = some slot free AND (request register empty OR acc_req_valid_o&&acc_req_ready_i this cycle).
- issue_ready_o = issue_valid_i && (!match || can_take); this is combinational.
- issue_accept_o = issue_ready_o && match.
- Non-matching instruction: ready=1, accept=0 in the same cycle; no state change.
- Accepted issue:
  - Allocates the lowest-index free slot and stores {id, rd=instr[11:7]}.
  - Loads the request register with funct7/funct3, opa, opb and the slot tag.
  - acc_req_valid_o rises on the next cycle and holds, with stable payload, until acc_req_ready_i.
  - Latency is 1 cycle from issue handshake to request.
- Back-to-back issue at 1/cycle is possible while the accelerator keeps acc_req_ready_i=1.
- All slots valid: ready=0 for matching instructions; non-matching instructions are still rejected immediately.
- Completion (acc_rsp_valid_i with valid slot T), at cycle N:
  - The slot is freed at the end of cycle N.
  - In cycle N+1: result_valid_o=1, result_id_o/result_rd_o from slot T, result_data_o=acc_rsp_data_i.
  - Results follow completion order, not issue order. Max 1 per cycle, no backpressure.
- Result outputs hold their last values while result_valid_o=0.
- A slot freed in cycle N is not allocatable until N+1; a completion and an issue in the same cycle never share a slot.
- Completion to a non-valid slot: ignored, no result, err_o set to 1 until reset.
- busy_o = |slot_valid || acc_req_valid_o, registered.
- Reset mid-operation: pending request and all slots are discarded; any later stale responses set err_o.

Decomposition:
- Package cix_pkg:
  - CIX_ID_W=4, CIX_RD_W=5, CIX_XLEN=32.
  - Slot-entry struct {valid, id, rd}.
  - Field-position constants for opcode, rd, funct3, funct7.
- Sub-module cix_slot_table: NUM_SLOTS entries, lowest-free priority allocator, free/lookup by tag, and a full flag.

Test Plan:
- Reject: instr=0x00000033, valid=1 → same cycle ready=1, accept=0; no acc_req_valid_o; busy_o stays 0.
- Single op:
  - Stimulus: instr=0x0020858B (rd=11, funct3=0), opa=5, opb=7, id=3; accelerator responds tag 0, data 12, 2 cycles later.
  - Response: accept=1; acc_req_valid_o next cycle with tag=0, opa=5, opb=7; result_valid one cycle after the response, with id=3, rd=11, data=12.
- Full: 4 matching issues with acc_req_ready_i=1 and no responses → tags 0,1,2,3; the 5th matching issue sees ready=0; a non-matching issue in the same state sees ready=1, accept=0.
- Out-of-order:
  - Stimulus: issue ids 1,2,3; respond with tags 2, 0, 1 on consecutive cycles.
  - Response: results on 3 consecutive cycles with ids 3,1,2.
  - Then a new issue in the cycle of a completion gets a different slot from the one being freed.
- Backpressure: hold acc_req_ready_i=0 for 5 cycles → acc_req_valid_o and its payload stay stable; a second matching issue sees ready=0 until ready_i rises, then is accepted in that same cycle.
- Error and reset:
  - Response to tag 2 with no slots valid → no result_valid_o, err_o=1 and stays high.
  - Assert resetn=0 asynchronously with 2 slots busy → outputs 0 immediately; busy_o=0 after release.
